// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the ibus and dbus masters.
// The granted command is registered; completion on waitrequest low or timeout.
module mem_bus_arbiter #(
   parameter bit DBUS_PRIORITY = 1'b1,
   parameter int TIMEOUT       = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ibus_addr,
   input  logic [3:0]  ibus_byte_en,
   input  logic        ibus_read,
   input  logic        ibus_write,
   input  logic [31:0] ibus_write_data,
   output logic [31:0] ibus_read_data,
   output logic        ibus_stall,
   output logic        ibus_error,
   input  logic [31:0] dbus_addr,
   input  logic [3:0]  dbus_byte_en,
   input  logic        dbus_read,
   input  logic        dbus_write,
   input  logic [31:0] dbus_write_data,
   output logic [31:0] dbus_read_data,
   output logic        dbus_stall,
   output logic        dbus_error,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_byte_en,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   input  logic        mem_waitrequest
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t        state, state_nx;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [3:0]    lat_be;
   logic          lat_write;
   logic          last_d;
   logic [CW-1:0] wait_cnt;

   logic i_req, d_req, busy, tmo_hit, done, decide;
   logic i_cand, d_cand, win_i, win_d;

   assign i_req   = ibus_read | ibus_write;
   assign d_req   = dbus_read | dbus_write;
   assign busy    = (state != IDLE);
   assign tmo_hit = (TIMEOUT > 0) && busy && mem_waitrequest
                    && (wait_cnt == CW'(TIMEOUT));
   assign done    = busy & (~mem_waitrequest | tmo_hit);
   assign decide  = ~busy | done;

   // The completing owner sits out one decision so the other port gets in.
   assign i_cand = i_req & ~(done & (state == BUSY_I));
   assign d_cand = d_req & ~(done & (state == BUSY_D));
   assign win_d  = d_cand & (~i_cand | DBUS_PRIORITY | ~last_d);
   assign win_i  = i_cand & ~win_d;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (decide) begin
         unique case (1'b1)
            win_d:   state_nx = BUSY_D;
            win_i:   state_nx = BUSY_I;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         lat_write <= 1'b0;
         last_d    <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         if (decide && (win_i || win_d)) begin
            lat_addr  <= win_d ? dbus_addr : ibus_addr;
            lat_wdata <= win_d ? dbus_write_data : ibus_write_data;
            lat_be    <= win_d ? dbus_byte_en : ibus_byte_en;
            lat_write <= win_d ? dbus_write : ibus_write;
            last_d    <= win_d;
         end
         if (decide) wait_cnt <= '0;
         else        wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign mem_addr       = lat_addr;
   assign mem_byte_en    = lat_be;
   assign mem_write_data = lat_wdata;

   always_comb begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      ibus_stall     = i_req;
      dbus_stall     = d_req;
      ibus_error     = 1'b0;
      dbus_error     = 1'b0;
      ibus_read_data = '0;
      dbus_read_data = '0;
      unique case (state)
         BUSY_I: begin
            mem_read  = ~lat_write;
            mem_write = lat_write;
            if (done && i_req) begin
               ibus_stall = 1'b0;
               ibus_error = tmo_hit;
               if (!tmo_hit && !lat_write) ibus_read_data = mem_read_data;
            end
         end
         BUSY_D: begin
            mem_read  = ~lat_write;
            mem_write = lat_write;
            if (done && d_req) begin
               dbus_stall = 1'b0;
               dbus_error = tmo_hit;
               if (!tmo_hit && !lat_write) dbus_read_data = mem_read_data;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a priority instance and a round-robin/timeout
// instance share stimulus; a transaction-level model checks both every cycle.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ibus_addr = '0, dbus_addr = '0;
   logic [3:0]  ibus_byte_en = '0, dbus_byte_en = '0;
   logic        ibus_read = 0, ibus_write = 0, dbus_read = 0, dbus_write = 0;
   logic [31:0] ibus_write_data = '0, dbus_write_data = '0;
   logic [31:0] mem_read_data = '0;
   logic        mem_waitrequest = 1'b0;

   logic [31:0] a_ibus_read_data, a_dbus_read_data, a_mem_addr, a_mem_write_data;
   logic [31:0] b_ibus_read_data, b_dbus_read_data, b_mem_addr, b_mem_write_data;
   logic        a_ibus_stall, a_dbus_stall, a_ibus_error, a_dbus_error;
   logic        b_ibus_stall, b_dbus_stall, b_ibus_error, b_dbus_error;
   logic [3:0]  a_mem_byte_en, b_mem_byte_en;
   logic        a_mem_read, a_mem_write, b_mem_read, b_mem_write;

   mem_bus_arbiter #(.DBUS_PRIORITY(1'b1), .TIMEOUT(0)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .ibus_addr(ibus_addr), .ibus_byte_en(ibus_byte_en),
      .ibus_read(ibus_read), .ibus_write(ibus_write),
      .ibus_write_data(ibus_write_data), .ibus_read_data(a_ibus_read_data),
      .ibus_stall(a_ibus_stall), .ibus_error(a_ibus_error),
      .dbus_addr(dbus_addr), .dbus_byte_en(dbus_byte_en),
      .dbus_read(dbus_read), .dbus_write(dbus_write),
      .dbus_write_data(dbus_write_data), .dbus_read_data(a_dbus_read_data),
      .dbus_stall(a_dbus_stall), .dbus_error(a_dbus_error),
      .mem_addr(a_mem_addr), .mem_byte_en(a_mem_byte_en),
      .mem_read(a_mem_read), .mem_write(a_mem_write),
      .mem_write_data(a_mem_write_data), .mem_read_data(mem_read_data),
      .mem_waitrequest(mem_waitrequest)
   );

   mem_bus_arbiter #(.DBUS_PRIORITY(1'b0), .TIMEOUT(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .ibus_addr(ibus_addr), .ibus_byte_en(ibus_byte_en),
      .ibus_read(ibus_read), .ibus_write(ibus_write),
      .ibus_write_data(ibus_write_data), .ibus_read_data(b_ibus_read_data),
      .ibus_stall(b_ibus_stall), .ibus_error(b_ibus_error),
      .dbus_addr(dbus_addr), .dbus_byte_en(dbus_byte_en),
      .dbus_read(dbus_read), .dbus_write(dbus_write),
      .dbus_write_data(dbus_write_data), .dbus_read_data(b_dbus_read_data),
      .dbus_stall(b_dbus_stall), .dbus_error(b_dbus_error),
      .mem_addr(b_mem_addr), .mem_byte_en(b_mem_byte_en),
      .mem_read(b_mem_read), .mem_write(b_mem_write),
      .mem_write_data(b_mem_write_data), .mem_read_data(mem_read_data),
      .mem_waitrequest(mem_waitrequest)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit mon   = 1'b0;

   // Model: owner 0=none 1=ibus 2=dbus; the command record; last grantee.
   int          m_own[2];
   int          m_last[2];
   int          m_wait[2];
   logic [31:0] m_addr[2];
   logic [31:0] m_wd[2];
   logic [3:0]  m_be[2];
   logic        m_wr[2];

   function automatic bit prio_of(int k);
      return (k == 0);
   endfunction

   function automatic int tmo_of(int k);
      return (k == 0) ? 0 : 4;
   endfunction

   function automatic bit hit_of(int k);
      return (m_own[k] != 0) && (tmo_of(k) > 0) && mem_waitrequest
             && (m_wait[k] == tmo_of(k));
   endfunction

   function automatic bit done_of(int k);
      return (m_own[k] != 0) && (!mem_waitrequest || hit_of(k));
   endfunction

   function automatic logic [137:0] expect_out(int k);
      bit ireq, dreq, busy, hit, done, ist, dst, ie, de;
      logic [31:0] ird, drd;
      ireq = ibus_read | ibus_write;
      dreq = dbus_read | dbus_write;
      busy = (m_own[k] != 0);
      hit  = hit_of(k);
      done = done_of(k);
      ist  = ireq && !(done && m_own[k] == 1);
      dst  = dreq && !(done && m_own[k] == 2);
      ie   = (m_own[k] == 1) && hit && ireq;
      de   = (m_own[k] == 2) && hit && dreq;
      ird  = (m_own[k] == 1 && done && ireq && !hit && !m_wr[k]) ? mem_read_data : 32'h0;
      drd  = (m_own[k] == 2 && done && dreq && !hit && !m_wr[k]) ? mem_read_data : 32'h0;
      return {busy && !m_wr[k], busy && m_wr[k], m_addr[k], m_be[k], m_wd[k],
              ist, dst, ie, de, ird, drd};
   endfunction

   task automatic model_step(int k);
      bit ic, dc, done;
      int w;
      if (!rst_n) begin
         m_own[k] = 0; m_last[k] = 1; m_wait[k] = 0;
         m_addr[k] = '0; m_wd[k] = '0; m_be[k] = '0; m_wr[k] = 1'b0;
      end else if (m_own[k] == 0 || done_of(k)) begin
         done = done_of(k);
         ic = (ibus_read | ibus_write) && !(done && m_own[k] == 1);
         dc = (dbus_read | dbus_write) && !(done && m_own[k] == 2);
         if (ic && dc) w = prio_of(k) ? 2 : ((m_last[k] == 2) ? 1 : 2);
         else if (dc)  w = 2;
         else if (ic)  w = 1;
         else          w = 0;
         m_own[k] = w;
         m_wait[k] = 0;
         if (w == 2) begin
            m_addr[k] = dbus_addr; m_wd[k] = dbus_write_data;
            m_be[k] = dbus_byte_en; m_wr[k] = dbus_write; m_last[k] = 2;
         end else if (w == 1) begin
            m_addr[k] = ibus_addr; m_wd[k] = ibus_write_data;
            m_be[k] = ibus_byte_en; m_wr[k] = ibus_write; m_last[k] = 1;
         end
      end else begin
         m_wait[k]++;
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k);
   end

   logic [137:0] act_a, act_b, exp_a, exp_b;
   always @(negedge clk) begin
      if (mon) begin
         act_a = {a_mem_read, a_mem_write, a_mem_addr, a_mem_byte_en, a_mem_write_data,
                  a_ibus_stall, a_dbus_stall, a_ibus_error, a_dbus_error,
                  a_ibus_read_data, a_dbus_read_data};
         act_b = {b_mem_read, b_mem_write, b_mem_addr, b_mem_byte_en, b_mem_write_data,
                  b_ibus_stall, b_dbus_stall, b_ibus_error, b_dbus_error,
                  b_ibus_read_data, b_dbus_read_data};
         exp_a = expect_out(0);
         exp_b = expect_out(1);
         total += 2;
         if (act_a !== exp_a) begin
            bad++;
            $display("FAIL model_a t=%0t got=%h want=%h", $time, act_a, exp_a);
         end
         if (act_b !== exp_b) begin
            bad++;
            $display("FAIL model_b t=%0t got=%h want=%h", $time, act_b, exp_b);
         end
      end
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] seq_a[4];
   logic [31:0] seq_b[4];

   initial begin
      seq_a = '{32'h44, 32'h8000_0008, 32'h44, 32'h8000_0008};
      seq_b = '{32'h8000_0008, 32'h44, 32'h8000_0008, 32'h44};

      // reset
      cyc(); mon = 1'b1;
      cyc(); ibus_read = 1; #3;
      chk("rst_istall", a_ibus_stall, 1);
      chk("rst_mread", a_mem_read, 0);
      chk("rst_maddr", a_mem_addr, 0);
      chk("rst_rdata", a_ibus_read_data, 0);
      cyc(); ibus_read = 0; rst_n = 1;

      // single zero-wait read
      cyc();
      ibus_read = 1; ibus_addr = 32'h8000_0000; ibus_byte_en = 4'hF;
      mem_read_data = 32'h3C01_0001; #3;
      chk("rd_n_stall", a_ibus_stall, 1);
      chk("rd_n_mread", a_mem_read, 0);
      cyc(); #3;
      chk("rd_mread", a_mem_read, 1);
      chk("rd_maddr", a_mem_addr, 32'h8000_0000);
      chk("rd_stall", a_ibus_stall, 0);
      chk("rd_data", a_ibus_read_data, 32'h3C01_0001);
      cyc(); ibus_read = 0; #3;
      chk("rd_idle", a_mem_read, 0);

      // simultaneous requests: dbus first, then ibus with no bubble
      cyc();
      dbus_write = 1; dbus_addr = 32'h10; dbus_byte_en = 4'hF;
      dbus_write_data = 32'h1234_5678;
      ibus_read = 1; ibus_addr = 32'h8000_0004; mem_read_data = 32'hDEAD_BEEF; #3;
      chk("sim_n_istall", a_ibus_stall, 1);
      cyc(); #3;
      chk("sim_mwrite", a_mem_write, 1);
      chk("sim_wdata", a_mem_write_data, 32'h1234_5678);
      chk("sim_waddr", a_mem_addr, 32'h10);
      chk("sim_dstall", a_dbus_stall, 0);
      chk("sim_istall", a_ibus_stall, 1);
      cyc(); dbus_write = 0; #3;
      chk("sim_mread", a_mem_read, 1);
      chk("sim_raddr", a_mem_addr, 32'h8000_0004);
      chk("sim_istall2", a_ibus_stall, 0);
      chk("sim_rdata", a_ibus_read_data, 32'hDEAD_BEEF);
      cyc(); ibus_read = 0;

      // lone dbus access, then a tie from IDLE: priority vs round-robin
      cyc(); dbus_read = 1; dbus_addr = 32'h40; mem_read_data = 32'h0BAD_F00D;
      cyc(); #3;
      chk("solo_dstall", a_dbus_stall, 0);
      chk("solo_ddata", a_dbus_read_data, 32'h0BAD_F00D);
      cyc(); dbus_read = 0;
      cyc();
      ibus_read = 1; ibus_addr = 32'h8000_0008;
      dbus_read = 1; dbus_addr = 32'h44;
      for (int i = 0; i < 4; i++) begin
         cyc(); #3;
         chk($sformatf("rr_a%0d", i), a_mem_addr, seq_a[i]);
         chk($sformatf("rr_b%0d", i), b_mem_addr, seq_b[i]);
         chk($sformatf("rr_busy%0d", i), b_mem_read, 1);
      end
      cyc(); ibus_read = 0; dbus_read = 0;

      // three wait states on a dbus read
      cyc();
      dbus_read = 1; dbus_addr = 32'h20; dbus_byte_en = 4'b0011;
      mem_waitrequest = 1; mem_read_data = 32'h55AA_55AA;
      for (int i = 0; i < 3; i++) begin
         cyc(); #3;
         chk($sformatf("ws_mread%0d", i), a_mem_read, 1);
         chk($sformatf("ws_addr%0d", i), a_mem_addr, 32'h20);
         chk($sformatf("ws_be%0d", i), a_mem_byte_en, 4'b0011);
         chk($sformatf("ws_stall%0d", i), a_dbus_stall, 1);
      end
      cyc(); mem_waitrequest = 0; #3;
      chk("ws_addr3", a_mem_addr, 32'h20);
      chk("ws_stall3", a_dbus_stall, 0);
      chk("ws_data", a_dbus_read_data, 32'h55AA_55AA);
      cyc(); dbus_read = 0;

      // timeout on the TIMEOUT=4 instance
      cyc();
      dbus_read = 1; dbus_addr = 32'h30; dbus_byte_en = 4'hF;
      mem_waitrequest = 1; mem_read_data = 32'hFFFF_FFFF;
      for (int i = 1; i <= 4; i++) begin
         cyc(); #3;
         chk($sformatf("to_err%0d", i), b_dbus_error, 0);
         chk($sformatf("to_stall%0d", i), b_dbus_stall, 1);
      end
      cyc(); #3;
      chk("to_err5", b_dbus_error, 1);
      chk("to_stall5", b_dbus_stall, 0);
      chk("to_data5", b_dbus_read_data, 0);
      chk("to_a_stall", a_dbus_stall, 1);
      cyc(); dbus_read = 0; #3;
      chk("to_b_mread", b_mem_read, 0);
      chk("to_b_err6", b_dbus_error, 0);
      chk("to_a_mread", a_mem_read, 1);

      // reset in the middle of the stuck transaction
      cyc(); rst_n = 0; #3;
      chk("mrst_before", a_mem_read, 1);
      cyc(); #3;
      chk("mrst_mread", a_mem_read, 0);
      chk("mrst_mwrite", a_mem_write, 0);
      cyc(); rst_n = 1; mem_waitrequest = 0;

      // ibus abandons after one wait cycle, queued dbus write follows
      cyc();
      ibus_read = 1; ibus_addr = 32'h100; mem_waitrequest = 1;
      mem_read_data = 32'h7777_7777;
      cyc();
      dbus_write = 1; dbus_addr = 32'h200; dbus_write_data = 32'hCAFE_F00D;
      dbus_byte_en = 4'hF; #3;
      chk("ab_mread", a_mem_read, 1);
      chk("ab_addr", a_mem_addr, 32'h100);
      chk("ab_istall", a_ibus_stall, 1);
      cyc(); ibus_read = 0; mem_waitrequest = 0; #3;
      chk("ab_run", a_mem_read, 1);
      chk("ab_idata", a_ibus_read_data, 0);
      chk("ab_dstall", a_dbus_stall, 1);
      cyc(); #3;
      chk("ab_mwrite", a_mem_write, 1);
      chk("ab_waddr", a_mem_addr, 32'h200);
      chk("ab_wdata", a_mem_write_data, 32'hCAFE_F00D);
      chk("ab_dstall2", a_dbus_stall, 0);
      cyc(); dbus_write = 0;

      // read and write together count as a write
      cyc();
      ibus_read = 1; ibus_write = 1; ibus_addr = 32'h300;
      ibus_write_data = 32'hA5A5_A5A5; mem_read_data = 32'h1111_1111;
      cyc(); #3;
      chk("rw_mwrite", a_mem_write, 1);
      chk("rw_mread", a_mem_read, 0);
      chk("rw_wdata", a_mem_write_data, 32'hA5A5_A5A5);
      chk("rw_idata", a_ibus_read_data, 0);
      chk("rw_stall", a_ibus_stall, 0);
      cyc(); ibus_read = 0; ibus_write = 0;
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
